acum_buffer_p: RTL and testbench
================================

# acum_buffer_p

Parametrised accumulation buffer at the bottom of the GEMM systolic array. Each accepted beat carries one row of COLS signed partial sums; the block overwrites or accumulates them into a circular accumulator FIFO, or, on the final K-tile, retires the finished row into an output FIFO drained through a valid/ready handshake toward the store path. Compared with the fixed 4×24→32, depth-16 buffer, it adds:
- generic width, depth and column count;
- input backpressure;
- occupancy counters;
- sticky underflow detection;
- optional saturating arithmetic.

## Interface
Parameters:
- COLS, 4: columns per beat.
- IN_W, 24: signed input width per column.
- ACC_W, 32: accumulator and output width per column; must satisfy ACC_W >= IN_W.
- DEPTH, 16: entries in each FIFO; power of two, >= 2.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- i_valid  in  1  input beat present.
- i_ready  out  1  block accepts beat this cycle.
- i_store  in  1  beat is final tile: result goes to output FIFO.
- i_overwrite  in  1  result = input only; accumulator head not read or popped.
- i_data  in  COLS*IN_W  column c at bits [c*IN_W +: IN_W].
- o_valid  out  1  output FIFO non-empty.
- o_ready  in  1  consumer takes head.
- o_data  out  COLS*ACC_W  output head, column c at [c*ACC_W +: ACC_W].
- acc_count  out  $clog2(DEPTH+1)  accumulator FIFO occupancy.
- out_count  out  $clog2(DEPTH+1)  output FIFO occupancy.
- err_underflow  out  1  sticky: accumulate beat found accumulator empty.
- clr_err  in  1  synchronous clear of err_underflow.

## Operation
- Accept: acc = i_valid && i_ready.
- i_ready is combinational from the mode inputs and the FIFO state:
  - i_store=1: i_ready = !out_full.
  - i_store=0, i_overwrite=1: i_ready = !acc_full.
  - i_store=0, i_overwrite=0: i_ready = 1. The pop and push keep the count constant; the empty case pushes into a non-full FIFO.
- Per column: ext = sign-extend(i_data[c]) to ACC_W. The result is ext when i_overwrite, otherwise head[c] + ext.
- Accumulator pop on accept when !i_overwrite. Push on accept when !i_store.
- Output FIFO push on accept when i_store. Pop when o_valid && o_ready.
- Underflow: accumulate beat (!i_overwrite) accepted with acc_count=0. Head is treated as 0, no pop occurs, and err_underflow is set. The push still happens if !i_store.
- err_underflow: clr_err clears it; a set in the same cycle wins over clr_err.
- Both FIFOs are first-word-fall-through. The head is read combinationally from memory.
- Pointers wrap modulo DEPTH.
- o_data is forced to 0 while o_valid=0.
- No internal state machine beyond FIFO pointers and counters. Mode is per beat, so modes may change every cycle.

## Timing
- Reset values:
  - i_ready=1.
  - o_valid=0, o_data=0.
  - acc_count=0, out_count=0.
  - err_underflow=0.
  - All pointers 0.
  - Memory contents are not reset.
- Reset mid-stream discards every entry immediately (asynchronous).
- Latency: a beat accepted in cycle n is at the output head, or the accumulator head, from cycle n+1.
  - No bypass: an entry pushed in cycle n cannot be popped in cycle n.
  - The output FIFO empty in cycle n gives o_valid=0 that cycle even if a store beat is accepted.
- Output FIFO full with a simultaneous pop: i_ready stays 0. No same-cycle credit is taken, so i_ready has no combinational path from o_ready.
- Output FIFO simultaneous push and pop: out_count unchanged.
- Accumulator full, accumulate beat: pop and push in the same cycle are legal and count stays DEPTH.
- Counters are registered and update on the clock edge after the event.
- Throughput: one beat per cycle when not backpressured.

## Configuration
- ACUM_BUF_SAT_EN defined: each column sum clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on signed overflow. Overwrite results never saturate.
- ACUM_BUF_SAT_EN undefined: the sum wraps modulo 2^ACC_W in two's complement. No clamping logic is generated.

## Test plan
- Defaults, one overwrite/no-store beat of {4,3,2,1}, then accumulate with i_store=1 data {10,10,10,10} -> o_data columns {14,13,12,11}, o_valid rises the cycle after the store accept, acc_count returns to 0.
- 16 overwrite beats, i_store=0 -> acc_count=16, i_ready=0 on a 17th overwrite beat; an accumulate beat is still accepted with acc_count staying 16.
- 16 store beats with o_ready=0 -> out_count=16, i_ready=0 for store; release o_ready -> 16 entries drain in order on consecutive cycles, o_data=0 after the last.
- Accumulate beat with acc_count=0, data -5 -> output -5 (sign-extended 0xFFFFFFFB), err_underflow=1 and held; clr_err -> 0 next cycle.
- Head 0x7FFFFFF0 plus input 0x000020 -> 0x7FFFFFFF with ACUM_BUF_SAT_EN, 0x80000010 without.
- Assert rst with 3 entries in each FIFO -> counts 0, o_valid=0 immediately; next beat behaves as after power-up.

Source files
------------

// File: rtl/acum_buffer_p.sv
// ---------------------------------------------------------------------------
// acum_buffer_p -- accumulation buffer below the GEMM systolic array.
//
// Each accepted beat carries one row of COLS signed partial sums. The row
// either overwrites or accumulates into a circular accumulator FIFO. On the
// final K-tile (i_store) the finished row goes into an output FIFO instead,
// and that FIFO is drained toward the store path with a valid/ready handshake.
//
// Build option:
//   ACUM_BUF_SAT_EN  defined   -> column sums clamp on signed overflow
//                    undefined -> column sums wrap in two's complement
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_valid/i_ready  input beat handshake (i_ready depends on mode and FIFO state)
//   i_store          beat is the final tile; result goes to the output FIFO
//   i_overwrite      result = input; accumulator head is not read or popped
//   i_data           COLS x IN_W signed columns, column c at [c*IN_W +: IN_W]
//   o_valid/o_ready  output FIFO handshake; o_valid = output FIFO non-empty
//   o_data           output head, column c at [c*ACC_W +: ACC_W]; 0 when empty
//   acc_count        accumulator FIFO occupancy
//   out_count        output FIFO occupancy
//   err_underflow    sticky: an accumulate beat found the accumulator empty
//   clr_err          synchronous clear of err_underflow (a new set wins)
// ---------------------------------------------------------------------------
module acum_buffer_p #(
  parameter int COLS  = 4,
  parameter int IN_W  = 24,
  parameter int ACC_W = 32,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic                        i_store,
  input  logic                        i_overwrite,
  input  logic [COLS*IN_W-1:0]        i_data,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [COLS*ACC_W-1:0]       o_data,
  output logic [$clog2(DEPTH+1)-1:0]  acc_count,
  output logic [$clog2(DEPTH+1)-1:0]  out_count,
  output logic                        err_underflow,
  input  logic                        clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [COLS*ACC_W-1:0] acc_mem [DEPTH];
  logic [COLS*ACC_W-1:0] out_mem [DEPTH];

  logic [AW-1:0] acc_wr, acc_rd, out_wr, out_rd;

  logic acc_full, acc_empty, out_full;
  logic accept, acc_push, acc_pop, out_push, out_pop, underflow;
  logic [COLS*ACC_W-1:0] acc_head, result;

  assign acc_full  = (acc_count == FULL_CNT);
  assign acc_empty = (acc_count == '0);
  assign out_full  = (out_count == FULL_CNT);

  // Readiness never looks at o_ready: a full output FIFO stays not-ready even
  // while it is being popped, which keeps o_ready off the input path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    i_ready = 1'b1;
    if (i_store)          i_ready = !out_full;
    else if (i_overwrite) i_ready = !acc_full;
  end

  assign accept    = i_valid && i_ready;
  assign underflow = accept && !i_overwrite && acc_empty;
  assign acc_pop   = accept && !i_overwrite && !acc_empty;
  assign acc_push  = accept && !i_store;
  assign out_push  = accept && i_store;
  assign out_pop   = o_valid && o_ready;

  // An empty accumulator reads as zero so an underflowing beat adds to nothing.
  assign acc_head = acc_empty ? '0 : acc_mem[acc_rd];

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic signed [IN_W-1:0]  in_c;
    logic signed [ACC_W-1:0] ext_c, head_c, sum_c, res_c;

    assign in_c   = i_data[c*IN_W +: IN_W];
    assign ext_c  = ACC_W'(in_c);
    assign head_c = acc_head[c*ACC_W +: ACC_W];
    assign sum_c  = head_c + ext_c;

`ifdef ACUM_BUF_SAT_EN
    logic ovf;
    // Overflow only when both operands share a sign the sum does not.
    assign ovf   = (head_c[ACC_W-1] == ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != head_c[ACC_W-1]);
    assign res_c = i_overwrite ? ext_c
                 : ovf ? (head_c[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}})
                 : sum_c;
`else
    assign res_c = i_overwrite ? ext_c : sum_c;
`endif

    assign result[c*ACC_W +: ACC_W] = res_c;
  end

  // NOTE: FIFO storage has no reset; pointers and counts define validity, and resetting memory would cost a reset tree for nothing.
  always_ff @(posedge clk) begin
    if (acc_push) acc_mem[acc_wr] <= result;
    if (out_push) out_mem[out_wr] <= result;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      acc_wr        <= '0;
      acc_rd        <= '0;
      out_wr        <= '0;
      out_rd        <= '0;
      acc_count     <= '0;
      out_count     <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (acc_push) acc_wr <= acc_wr + AW'(1);
      if (acc_pop)  acc_rd <= acc_rd + AW'(1);
      if (out_push) out_wr <= out_wr + AW'(1);
      if (out_pop)  out_rd <= out_rd + AW'(1);

      case ({acc_push, acc_pop})
        2'b10:   acc_count <= acc_count + CW'(1);
        2'b01:   acc_count <= acc_count - CW'(1);
        default: acc_count <= acc_count;
      endcase

      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + CW'(1);
        2'b01:   out_count <= out_count - CW'(1);
        default: out_count <= out_count;
      endcase

      if (underflow)    err_underflow <= 1'b1;
      else if (clr_err) err_underflow <= 1'b0;
    end
  end

  assign o_valid = (out_count != '0);
  assign o_data  = o_valid ? out_mem[out_rd] : '0;

endmodule

// File: tb/tb_acum_buffer_p.sv
// ---------------------------------------------------------------------------
// tb_acum_buffer_p -- self-checking bench for acum_buffer_p (default params).
// A vector table covers basic accumulate/store, underflow and error clearing;
// hand-written sequences cover full FIFOs, draining, saturation and reset.
// ---------------------------------------------------------------------------
module tb_acum_buffer_p;

  localparam int COLS = 4, IN_W = 24, ACC_W = 32, DEPTH = 16;
  localparam int CW = $clog2(DEPTH+1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_valid, i_ready, i_store, i_overwrite;
  logic [COLS*IN_W-1:0]   i_data;
  logic                   o_valid, o_ready;
  logic [COLS*ACC_W-1:0]  o_data;
  logic [CW-1:0]          acc_count, out_count;
  logic                   err_underflow, clr_err;

  int n_checks = 0;
  int n_errors = 0;

  acum_buffer_p #(.COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_store(i_store), .i_overwrite(i_overwrite),
    .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .acc_count(acc_count), .out_count(out_count),
    .err_underflow(err_underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic           v, st, ow, ordy, clr;
    logic [95:0]    d;
    logic           ir, ov;
    logic [127:0]   od;
    int             ac, oc;
    logic           err;
  } vec_t;

  function automatic logic [95:0] pin(int a, int b, int c, int d);
    logic [95:0] r;
    r[0  +: 24] = 24'(a);
    r[24 +: 24] = 24'(b);
    r[48 +: 24] = 24'(c);
    r[72 +: 24] = 24'(d);
    return r;
  endfunction

  function automatic logic [127:0] pout(int a, int b, int c, int d);
    logic [127:0] r;
    r[0  +: 32] = 32'(a);
    r[32 +: 32] = 32'(b);
    r[64 +: 32] = 32'(c);
    r[96 +: 32] = 32'(d);
    return r;
  endfunction

  function automatic vec_t mk(logic v, logic st, logic ow, logic ordy, logic clr, logic [95:0] d,
                              logic ir, logic ov, logic [127:0] od, int ac, int oc, logic err);
    vec_t x;
    x.v = v; x.st = st; x.ow = ow; x.ordy = ordy; x.clr = clr; x.d = d;
    x.ir = ir; x.ov = ov; x.od = od; x.ac = ac; x.oc = oc; x.err = err;
    return x;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // i.e. they reflect the state before the next rising edge.
  task automatic drive(logic v, logic st, logic ow, logic ordy, logic clr, logic [95:0] d);
    @(negedge clk);
    i_valid = v; i_store = st; i_overwrite = ow; o_ready = ordy; clr_err = clr; i_data = d;
    #1;
  endtask

  vec_t vecs[15];
  logic [127:0] exp_sat;

  initial begin
    rst = 1'b1;
    i_valid = 0; i_store = 0; i_overwrite = 0; o_ready = 0; clr_err = 0; i_data = '0;
    #12;
    check("reset_i_ready",   128'(i_ready),       128'(1));
    check("reset_o_valid",   128'(o_valid),       128'(0));
    check("reset_o_data",    o_data,              128'(0));
    check("reset_acc_count", 128'(acc_count),     128'(0));
    check("reset_out_count", 128'(out_count),     128'(0));
    check("reset_err",       128'(err_underflow), 128'(0));
    rst = 1'b0;

    //           v  st ow or clr data                  ir ov od                       ac oc err
    vecs[0]  = mk(0, 0, 0, 0, 0, '0,                   1, 0, '0,                      0, 0, 0);
    vecs[1]  = mk(1, 0, 1, 0, 0, pin(4,3,2,1),         1, 0, '0,                      0, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, pin(10,10,10,10),     1, 0, '0,                      1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, '0,                   1, 1, pout(14,13,12,11),       0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, '0,                   1, 1, pout(14,13,12,11),       0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, '0,                   1, 0, '0,                      0, 0, 0);
    vecs[6]  = mk(1, 1, 0, 0, 0, pin(-5,-5,-5,-5),     1, 0, '0,                      0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, '0,                   1, 1, pout(-5,-5,-5,-5),       0, 1, 1);
    vecs[8]  = mk(0, 0, 0, 1, 1, '0,                   1, 1, pout(-5,-5,-5,-5),       0, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, '0,                   1, 0, '0,                      0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 1, pin(7,7,7,7),         1, 0, '0,                      0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 1, '0,                   1, 0, '0,                      1, 0, 1);
    vecs[12] = mk(1, 1, 0, 0, 0, pin(1,2,3,4),         1, 0, '0,                      1, 0, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, '0,                   1, 1, pout(8,9,10,11),         0, 1, 0);
    vecs[14] = mk(0, 0, 0, 0, 0, '0,                   1, 0, '0,                      0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].st, vecs[i].ow, vecs[i].ordy, vecs[i].clr, vecs[i].d);
      check($sformatf("row%0d_i_ready", i),   128'(i_ready),       128'(vecs[i].ir));
      check($sformatf("row%0d_o_valid", i),   128'(o_valid),       128'(vecs[i].ov));
      check($sformatf("row%0d_o_data", i),    o_data,              vecs[i].od);
      check($sformatf("row%0d_acc_count", i), 128'(acc_count),     128'(vecs[i].ac));
      check($sformatf("row%0d_out_count", i), 128'(out_count),     128'(vecs[i].oc));
      check($sformatf("row%0d_err", i),       128'(err_underflow), 128'(vecs[i].err));
    end

    // Fill the accumulator with 16 overwrite beats (value k in every column).
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 0, 1, 0, 0, pin(k, k, k, k));
      check($sformatf("fill_acc_ready%0d", k), 128'(i_ready), 128'(1));
    end
    drive(1, 0, 1, 0, 0, pin(99, 99, 99, 99));
    check("acc_full_count", 128'(acc_count), 128'(16));
    check("acc_full_ow_ready", 128'(i_ready), 128'(0));
    // Accumulate beat on a full accumulator: accepted, count stays 16.
    drive(1, 0, 0, 0, 0, pin(100, 100, 100, 100));
    check("acc_full_accum_ready", 128'(i_ready), 128'(1));
    check("acc_full_no_accept", 128'(acc_count), 128'(16));
    // Move the accumulator into the output FIFO: heads 1..15 then 0+100, each +1000.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 1, 0, 0, 0, pin(1000, 1000, 1000, 1000));
      check($sformatf("store_ready%0d", k), 128'(i_ready), 128'(1));
      if (k == 0) check("acc_after_pop_push", 128'(acc_count), 128'(16));
    end
    drive(1, 1, 0, 0, 0, pin(1000, 1000, 1000, 1000));
    check("out_full_count", 128'(out_count), 128'(16));
    check("out_full_ready", 128'(i_ready), 128'(0));
    check("acc_drained", 128'(acc_count), 128'(0));
    // o_ready high on a full output FIFO grants no same-cycle credit.
    drive(1, 1, 0, 1, 0, pin(1000, 1000, 1000, 1000));
    check("out_full_pop_ready", 128'(i_ready), 128'(0));
    check("drain0", o_data, pout(1001, 1001, 1001, 1001));
    for (int j = 1; j < DEPTH; j++) begin
      int e;
      e = (j < 15) ? 1001 + j : 1100;
      drive(0, 0, 0, 1, 0, '0);
      check($sformatf("drain%0d_valid", j), 128'(o_valid), 128'(1));
      check($sformatf("drain%0d", j), o_data, pout(e, e, e, e));
    end
    drive(0, 0, 0, 0, 0, '0);
    check("drained_valid", 128'(o_valid), 128'(0));
    check("drained_data", o_data, 128'(0));
    check("drained_count", 128'(out_count), 128'(0));

    // Build heads 0x7FFFFFF0 (col0) and -2^31 (col1), then push past the limits.
    drive(1, 0, 1, 0, 0, pin(32'h7FFFFF, -32'sh800000, 0, 0));
    for (int k = 0; k < 255; k++) drive(1, 0, 0, 0, 0, pin(32'h7FFFFF, -32'sh800000, 0, 0));
    drive(1, 0, 0, 0, 0, pin(32'hF0, 0, 0, 0));
    drive(1, 1, 0, 0, 0, pin(32'h20, -1, 0, 0));
    drive(0, 0, 0, 0, 0, '0);
`ifdef ACUM_BUF_SAT_EN
    exp_sat = pout(32'h7FFFFFFF, 32'h80000000, 0, 0);
`else
    exp_sat = pout(32'h80000010, 32'h7FFFFFFF, 0, 0);
`endif
    check("sat_valid", 128'(o_valid), 128'(1));
    check("sat_data", o_data, exp_sat);
    check("sat_acc_empty", 128'(acc_count), 128'(0));
    check("sat_no_err", 128'(err_underflow), 128'(0));
    drive(0, 0, 0, 1, 0, '0);

    // Three entries in each FIFO, then an asynchronous reset mid-cycle.
    for (int k = 0; k < 3; k++) drive(1, 0, 1, 0, 0, pin(5, 5, 5, 5));
    for (int k = 0; k < 3; k++) drive(1, 1, 1, 0, 0, pin(6, 6, 6, 6));
    drive(0, 0, 0, 0, 0, '0);
    check("pre_rst_acc", 128'(acc_count), 128'(3));
    check("pre_rst_out", 128'(out_count), 128'(3));
    rst = 1'b1;
    #1;
    check("rst_acc", 128'(acc_count), 128'(0));
    check("rst_out", 128'(out_count), 128'(0));
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_data", o_data, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 0, 0, pin(4, 3, 2, 1));
    drive(1, 1, 0, 0, 0, pin(10, 10, 10, 10));
    check("post_rst_no_err", 128'(err_underflow), 128'(0));
    drive(0, 0, 0, 0, 0, '0);
    check("post_rst_valid", 128'(o_valid), 128'(1));
    check("post_rst_data", o_data, pout(14, 13, 12, 11));
    check("post_rst_acc", 128'(acc_count), 128'(0));
    check("post_rst_out", 128'(out_count), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
